// File: rtl/shifter_load_ctrl.sv
// shifter_load_ctrl
// Word scheduler between the video DMA and the shifter datapath (clk32 domain).
// Buffers fetched 16-bit screen words in a small FIFO, generates the pixel
// clock enable for the selected resolution, and issues one LOAD strobe plus
// word per 16-cycle slot while display enable is active. Overflow and
// underrun are reported as sticky flags.
//
// Build option: SHIFTER_UNDERRUN_REPEAT_EN
//   defined   - an underrun slot still pulses LOAD with the last issued word,
//               so the shifter repeats it (underrun is still flagged).
//   undefined - an underrun slot leaves LOAD low and DOUT unchanged.

module shifter_load_ctrl #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk32,
    input  logic                          nReset,
    input  logic [1:0]                    rez,
    input  logic                          DE,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [15:0]                   wr_data,
    input  logic                          err_clr,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          pixClkEn,
    output logic                          LOAD,
    output logic [15:0]                   DOUT,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          de_q;
    logic          de_qq;
    logic          de_rise;

    logic [1:0]    pcnt;
    logic [1:0]    pcnt_nxt;
    logic          pix_en_nxt;

    logic [3:0]    slot;
    logic          slot0;
    logic          empty;
    logic          pop;
    logic          under_evt;
    logic          issue;
    logic          wr_ok;
    logic          ovf_evt;
    logic          load_d;

    // ------------------------------------------------------------------
    // Derived controls
    // ------------------------------------------------------------------
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign de_rise = de_q & ~de_qq;

    // Slot-0 issue decision; flush overrides any pop in the same cycle
    always_comb begin
        slot0     = de_q & (slot == 4'd0);
        pop       = slot0 & ~empty & ~flush;
        under_evt = slot0 & empty;
`ifdef SHIFTER_UNDERRUN_REPEAT_EN
        issue     = pop | (under_evt & ~flush);
`else
        issue     = pop;
`endif
    end

    // A write into a full FIFO is only accepted when a pop frees a slot
    // in the same cycle; otherwise it is dropped and flagged.
    always_comb begin
        wr_ok   = wr_en & ~flush & (~full | pop);
        ovf_evt = wr_en & ~flush & full & ~pop;
    end

    // Pixel divider next value; enable is computed from the next count so
    // pixClkEn is high exactly while pcnt sits at the enabled phase.
    always_comb begin
        pcnt_nxt = de_rise ? 2'd0 : pcnt + 2'd1;
        if (rez[1])
            pix_en_nxt = 1'b1;
        else if (rez[0])
            pix_en_nxt = pcnt_nxt[0];
        else
            pix_en_nxt = (pcnt_nxt == 2'd3);
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Display-enable register and edge history
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            de_q  <= 1'b0;
            de_qq <= 1'b0;
        end else begin
            de_q  <= DE;
            de_qq <= de_q;
        end
    end

    // Pixel divider and registered pixel clock enable
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            pcnt     <= 2'd0;
            pixClkEn <= 1'b0;
        end else begin
            pcnt     <= pcnt_nxt;
            pixClkEn <= pix_en_nxt;
        end
    end

    // Slot counter: parked at 0 outside the active line, free-running mod 16 inside
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset)
            slot <= 4'd0;
        else if (!de_q)
            slot <= 4'd0;
        else
            slot <= slot + 4'd1;
    end

    // Word buffer contents; no reset needed, level gates every read
    always_ff @(posedge clk32) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers and exact occupancy
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Output word: loaded from the FIFO head on pop, otherwise held
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset)
            DOUT <= 16'h0000;
        else if (pop)
            DOUT <= mem[rd_ptr];
    end

    // LOAD is a two-cycle pulse after each issue; flush cuts it off
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            LOAD   <= 1'b0;
            load_d <= 1'b0;
        end else if (flush) begin
            LOAD   <= 1'b0;
            load_d <= 1'b0;
        end else begin
            LOAD   <= issue | load_d;
            load_d <= issue;
        end
    end

    // Sticky error flags; a new event beats a same-cycle clear
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ovf_evt)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (under_evt)
                underrun <= 1'b1;
            else if (err_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shifter_load_ctrl.sv
// Directed testbench for shifter_load_ctrl (FIFO_DEPTH = 8).
module tb_shifter_load_ctrl;

`ifdef SHIFTER_UNDERRUN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        clk32 = 1'b0;
    logic        nReset;
    logic [1:0]  rez;
    logic        DE;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        err_clr;
    logic        full;
    logic [3:0]  level;
    logic        pixClkEn;
    logic        LOAD;
    logic [15:0] DOUT;
    logic        overflow;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    shifter_load_ctrl #(.FIFO_DEPTH(8)) dut (
        .clk32(clk32), .nReset(nReset), .rez(rez), .DE(DE), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .err_clr(err_clr), .full(full),
        .level(level), .pixClkEn(pixClkEn), .LOAD(LOAD), .DOUT(DOUT),
        .overflow(overflow), .underrun(underrun)
    );

    always #5 clk32 = ~clk32;

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [15:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic do_clr();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0; rez = 2'd0; DE = 1'b0; flush = 1'b0;
        wr_en = 1'b0; wr_data = 16'h0; err_clr = 1'b0;
        #2;
        checks++; if (LOAD !== 1'b0) begin errors++; $display("FAIL reset_load: got %0b exp 0", LOAD); end
        checks++; if (DOUT !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h exp 0000", DOUT); end
        checks++; if (pixClkEn !== 1'b0) begin errors++; $display("FAIL reset_pix: got %0b exp 0", pixClkEn); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b exp 0", full); end
        checks++; if ({overflow, underrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {overflow, underrun}); end
        idle(2);
        nReset = 1'b1;
        idle(2);
    endtask

    task automatic test_pixclk();
        int exp_cnt [3] = '{16, 32, 64};
        for (int r = 0; r < 3; r++) begin
            int cnt = 0;
            rez = r[1:0];
            idle(4);
            repeat (64) begin
                tick();
                cnt += int'(pixClkEn);
            end
            checks++; if (cnt !== exp_cnt[r]) begin errors++; $display("FAIL pix_count_rez%0d: got %0d exp %0d", r, cnt, exp_cnt[r]); end
        end
        rez = 2'd0;
        idle(2);
    endtask

    task automatic test_pix_phase();
        logic [9:0] seen;
        seen = '0;
        DE = 1'b0; idle(3);
        DE = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            seen[i] = pixClkEn;
        end
        checks++; if (seen[9:2] !== 8'b1000_1000) begin errors++; $display("FAIL pix_phase: got %b exp 10001000", seen[9:2]); end
        DE = 1'b0; idle(3);
    endtask

    task automatic test_issue();
        logic exp_load;
        do_flush();
        do_write(16'h1111); do_write(16'h2222); do_write(16'h3333); do_write(16'h4444);
        checks++; if (level !== 4'd4) begin errors++; $display("FAIL issue_level_pre: got %0d exp 4", level); end
        DE = 1'b1;
        for (int i = 1; i <= 52; i++) begin
            tick();
            exp_load = (i == 2 || i == 3 || i == 18 || i == 19 || i == 34 || i == 35 || i == 50 || i == 51);
            checks++; if (LOAD !== exp_load) begin errors++; $display("FAIL issue_load_t%0d: got %0b exp %0b", i, LOAD, exp_load); end
            case (i)
                2:  begin checks++; if (DOUT !== 16'h1111 || level !== 4'd3) begin errors++; $display("FAIL issue_w0: got %h/%0d exp 1111/3", DOUT, level); end end
                18: begin checks++; if (DOUT !== 16'h2222 || level !== 4'd2) begin errors++; $display("FAIL issue_w1: got %h/%0d exp 2222/2", DOUT, level); end end
                34: begin checks++; if (DOUT !== 16'h3333 || level !== 4'd1) begin errors++; $display("FAIL issue_w2: got %h/%0d exp 3333/1", DOUT, level); end end
                50: begin checks++; if (DOUT !== 16'h4444 || level !== 4'd0) begin errors++; $display("FAIL issue_w3: got %h/%0d exp 4444/0", DOUT, level); end end
                default: ;
            endcase
        end
        DE = 1'b0; idle(3);
    endtask

    task automatic test_overflow();
        DE = 1'b0;
        do_flush(); do_clr();
        for (int i = 1; i <= 9; i++) begin
            do_write(16'(i));
            checks++; if (level !== 4'((i > 8) ? 8 : i) || full !== (i >= 8)) begin errors++; $display("FAIL ovf_level_w%0d: got %0d/%0b exp %0d/%0b", i, level, full, (i > 8) ? 8 : i, i >= 8); end
            if (i == 8) begin checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b exp 0", overflow); end end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b exp 1", overflow); end
        do_clr();
        checks++; if (overflow !== 1'b0 || level !== 4'd8) begin errors++; $display("FAIL ovf_clr: got %0b/%0d exp 0/8", overflow, level); end
        do_flush();
    endtask

    task automatic test_underrun();
        do_clr();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_clear: got %0b exp 0", underrun); end
        do_write(16'hABCD);
        DE = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 2) begin checks++; if (LOAD !== 1'b1 || DOUT !== 16'hABCD) begin errors++; $display("FAIL und_prepop: got %0b/%h exp 1/abcd", LOAD, DOUT); end end
            if (i == 17) begin checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_early: got %0b exp 0", underrun); end end
            if (i == 18) begin checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_set: got %0b exp 1", underrun); end end
            if (i >= 18) begin
                checks++; if (LOAD !== (REP && i < 20)) begin errors++; $display("FAIL und_load_t%0d: got %0b exp %0b", i, LOAD, REP && i < 20); end
                checks++; if (DOUT !== 16'hABCD) begin errors++; $display("FAIL und_dout_t%0d: got %h exp abcd", i, DOUT); end
            end
        end
        DE = 1'b0; idle(3);
    endtask

    task automatic test_flush();
        do_clr();
        do_write(16'h1111); do_write(16'h2222);
        DE = 1'b1;
        tick();
        flush = 1'b1; wr_en = 1'b1; wr_data = 16'hBEEF;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_level: got %0d exp 0", level); end
        checks++; if (LOAD !== 1'b0) begin errors++; $display("FAIL flush_load: got %0b exp 0", LOAD); end
        checks++; if (DOUT !== 16'hABCD) begin errors++; $display("FAIL flush_dout: got %h exp abcd", DOUT); end
        do_write(16'h5555);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL flush_wr_after: got %0d exp 1", level); end
        idle(15);
        checks++; if (LOAD !== 1'b1 || DOUT !== 16'h5555) begin errors++; $display("FAIL flush_next_word: got %0b/%h exp 1/5555", LOAD, DOUT); end
        DE = 1'b0; idle(3);
    endtask

    task automatic test_reset_midline();
        bit load_seen = 1'b0;
        do_flush();
        do_write(16'h7777); do_write(16'h8888);
        DE = 1'b1;
        idle(2);
        checks++; if (LOAD !== 1'b1 || DOUT !== 16'h7777) begin errors++; $display("FAIL rst_pre: got %0b/%h exp 1/7777", LOAD, DOUT); end
        #1 nReset = 1'b0;
        #1;
        checks++; if (LOAD !== 1'b0 || DOUT !== 16'h0 || level !== 4'd0) begin errors++; $display("FAIL rst_async: got %0b/%h/%0d exp 0/0000/0", LOAD, DOUT, level); end
        DE = 1'b0;
        tick();
        nReset = 1'b1;
        do_write(16'h9999);
        repeat (20) begin
            tick();
            if (LOAD !== 1'b0) load_seen = 1'b1;
        end
        checks++; if (load_seen !== 1'b0 || level !== 4'd1) begin errors++; $display("FAIL rst_no_pop: got %0b/%0d exp 0/1", load_seen, level); end
        DE = 1'b1;
        idle(2);
        checks++; if (LOAD !== 1'b1 || DOUT !== 16'h9999) begin errors++; $display("FAIL rst_new_line: got %0b/%h exp 1/9999", LOAD, DOUT); end
        DE = 1'b0; idle(3);
    endtask

    initial begin
        test_reset();
        test_pixclk();
        test_pix_phase();
        test_issue();
        test_overflow();
        test_underrun();
        test_flush();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
